// File: rtl/key_display_pkg.sv
// Shared types and default constants for the keypad-to-display controller.
// Contents:
//   key_state_t          - key acceptance FSM states (IDLE, HELD)
//   slot_t               - display multiplex slot (LEFT, RIGHT)
//   MUX_DIV_DEFAULT      - default clock cycles per digit slot
//   BLANK_CYCLES_DEFAULT - default guard cycles at the start of each slot
package key_display_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } key_state_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } slot_t;

  localparam int unsigned MUX_DIV_DEFAULT      = 1000;
  localparam int unsigned BLANK_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/digit_mux_timer.sv
// Digit multiplex timer: slot counter plus active-low anode enables.
// Optional macro ANODE_BLANK_EN turns both anodes off for the first
// BLANK_CYCLES cycles of every slot; without it BLANK_CYCLES has no effect.
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   slot      out  currently displayed slot (LEFT/RIGHT), registered
//   anode1_en out  left-digit enable, active-low, combinational
//   anode2_en out  right-digit enable, active-low, combinational
module digit_mux_timer
  import key_display_pkg::*;
#(
  parameter int unsigned MUX_DIV      = MUX_DIV_DEFAULT,
  parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEFAULT
) (
  input  logic  clk,
  input  logic  reset,
  output slot_t slot,
  output logic  anode1_en,
  output logic  anode2_en
);

  localparam int unsigned CNT_W = $clog2(MUX_DIV);

  logic [CNT_W-1:0] cnt;
  logic             blank_c;

  if (MUX_DIV < 2) begin : g_bad_mux_div
    $error("digit_mux_timer: MUX_DIV must be at least 2");
  end

  // Slot counter; slot flips on the wrap edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      slot <= LEFT;
    end else if (cnt == CNT_W'(MUX_DIV - 1)) begin
      cnt  <= '0;
      slot <= (slot == LEFT) ? RIGHT : LEFT;
    end else begin
      cnt  <= cnt + CNT_W'(1);
    end
  end

`ifdef ANODE_BLANK_EN
  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= MUX_DIV) begin : g_bad_blank
    $error("digit_mux_timer: BLANK_CYCLES must be in 1..MUX_DIV-1");
  end

  // Guard window hides the sshow transition at the start of each slot.
  assign blank_c = (32'(cnt) < BLANK_CYCLES);
`else
  if (BLANK_CYCLES == 0) begin : g_blank_unused
  end

  assign blank_c = 1'b0;
`endif

  // Active slot's anode low unless blanked; inactive anode always high.
  always_comb begin
    anode1_en = 1'b1;
    anode2_en = 1'b1;
    if (!blank_c) begin
      if (slot == LEFT) anode1_en = 1'b0;
      else              anode2_en = 1'b0;
    end
  end

endmodule

// File: rtl/key_display_ctrl.sv
// Keypad-to-display controller: accepts one key code per press into a
// two-digit shift history and multiplexes the shared seven-segment decoder.
// Optional macro ANODE_BLANK_EN enables per-slot anode blanking.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   key_valid    in   debounced key-held level
//   key_code     in   hex code of held key
//   key_accepted out  one-cycle pulse when a code is latched
//   digit_left   out  older digit
//   digit_right  out  newest digit
//   sshow        out  digit routed to the decoder (combinational)
//   anode1_en    out  left anode enable, active-low (combinational)
//   anode2_en    out  right anode enable, active-low (combinational)
module key_display_ctrl
  import key_display_pkg::*;
#(
  parameter int unsigned MUX_DIV      = MUX_DIV_DEFAULT,
  parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_accepted,
  output logic [3:0] digit_left,
  output logic [3:0] digit_right,
  output logic [3:0] sshow,
  output logic       anode1_en,
  output logic       anode2_en
);

  key_state_t state;
  key_state_t next_state;
  logic       accept_c;
  slot_t      slot;

  // Reset lands in HELD so a key held through reset must be re-pressed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= HELD;
    else        state <= next_state;
  end

  // Key FSM: accept once in IDLE, wait for release in HELD.
  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    case (state)
      IDLE: begin
        if (key_valid) begin
          accept_c   = 1'b1;
          next_state = HELD;
        end
      end
      HELD: begin
        if (!key_valid) next_state = IDLE;
      end
      default: next_state = HELD;
    endcase
  end

  // Digit history and accept pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_left   <= 4'h0;
      digit_right  <= 4'h0;
      key_accepted <= 1'b0;
    end else begin
      key_accepted <= accept_c;
      if (accept_c) begin
        digit_left  <= digit_right;
        digit_right <= key_code;
      end
    end
  end

  digit_mux_timer #(
    .MUX_DIV      (MUX_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .slot      (slot),
    .anode1_en (anode1_en),
    .anode2_en (anode2_en)
  );

  assign sshow = (slot == LEFT) ? digit_left : digit_right;

endmodule

// File: tb/tb_key_display_ctrl.sv
// Self-checking bench for key_display_ctrl (MUX_DIV=4, BLANK_CYCLES=1).
// Reference model: press history as two plain variables plus a "re-armed"
// flag, and the mux position derived arithmetically from edges since reset.
module tb_key_display_ctrl;

  localparam int unsigned MD = 4;
  localparam int unsigned BC = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_accepted;
  logic [3:0] digit_left;
  logic [3:0] digit_right;
  logic [3:0] sshow;
  logic       anode1_en;
  logic       anode2_en;

  int passed = 0;
  int total  = 0;
  int acc_count = 0;

  key_display_ctrl #(.MUX_DIV(MD), .BLANK_CYCLES(BC)) dut (
    .clk          (clk),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_accepted (key_accepted),
    .digit_left   (digit_left),
    .digit_right  (digit_right),
    .sshow        (sshow),
    .anode1_en    (anode1_en),
    .anode2_en    (anode2_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [3:0] m_left, m_right;
  logic       m_acc;
  bit         m_armed;   // a fresh press will be accepted
  int         m_edges;   // clock edges since reset release

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left = 4'h0; m_right = 4'h0; m_acc = 1'b0;
      m_armed = 1'b0; m_edges = 0;
    end else begin
      m_acc = 1'b0;
      if (m_armed && key_valid) begin
        m_left = m_right; m_right = key_code; m_acc = 1'b1; m_armed = 1'b0;
      end else if (!key_valid) begin
        m_armed = 1'b1;
      end
      m_edges++;
    end
  end

  function automatic logic [3:0] exp_sshow();
    return (((m_edges / MD) % 2) == 0) ? m_left : m_right;
  endfunction

  function automatic logic [1:0] exp_anodes();  // {anode1, anode2}
    bit right_slot;
    bit blank;
    right_slot = ((m_edges / MD) % 2) == 1;
`ifdef ANODE_BLANK_EN
    blank = (m_edges % MD) < BC;
`else
    blank = 1'b0;
`endif
    if (blank) return 2'b11;
    return right_slot ? 2'b10 : 2'b01;
  endfunction

  // Per-cycle compare against the model, away from the active edge.
  always @(posedge clk) begin
    logic [1:0] an;
    #2;
    an = exp_anodes();
    check("key_accepted", {3'b0, key_accepted}, {3'b0, m_acc});
    check("digit_left",   digit_left,  m_left);
    check("digit_right",  digit_right, m_right);
    check("sshow",        sshow,       exp_sshow());
    check("anode1_en",    {3'b0, anode1_en}, {3'b0, an[1]});
    check("anode2_en",    {3'b0, anode2_en}, {3'b0, an[0]});
    if (key_accepted) acc_count++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] a1_exp [8];
    logic [3:0] a2_exp [8];
    int a0;

    reset = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    cycles(3);

    // Reset with no key
    check("rst_left", digit_left, 4'h0);
    check("rst_right", digit_right, 4'h0);
    check("rst_acc", {3'b0, key_accepted}, 4'h0);
    check("rst_sshow", sshow, 4'h0);
`ifdef ANODE_BLANK_EN
    check("rst_an1", {3'b0, anode1_en}, 4'h1);
`else
    check("rst_an1", {3'b0, anode1_en}, 4'h0);
`endif
    check("rst_an2", {3'b0, anode2_en}, 4'h1);

    // Mux sequence over 8 cycles from reset release
`ifdef ANODE_BLANK_EN
    a1_exp = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1};
    a2_exp = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
`else
    a1_exp = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1};
    a2_exp = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
`endif
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("mux_an1[%0d]", i), {3'b0, anode1_en}, a1_exp[i]);
      check($sformatf("mux_an2[%0d]", i), {3'b0, anode2_en}, a2_exp[i]);
      @(negedge clk);
    end

    // Single press of 5
    a0 = acc_count;
    key_valid = 1'b1; key_code = 4'h5;
    cycles(10);
    check("p1_right", digit_right, 4'h5);
    check("p1_left", digit_left, 4'h0);
    check("p1_pulses", 4'(acc_count - a0), 4'd1);
    key_valid = 1'b0;
    cycles(2);

    // Second press shifts
    key_valid = 1'b1; key_code = 4'hA;
    cycles(5);
    check("p2_left", digit_left, 4'h5);
    check("p2_right", digit_right, 4'hA);

    // Code change while held is ignored
    a0 = acc_count;
    key_code = 4'h3;
    cycles(5);
    check("held_left", digit_left, 4'h5);
    check("held_right", digit_right, 4'hA);
    check("held_pulses", 4'(acc_count - a0), 4'd0);

    // Reset while held, released still held: no accept
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
    a0 = acc_count;
    cycles(5);
    check("rh_left", digit_left, 4'h0);
    check("rh_right", digit_right, 4'h0);
    check("rh_pulses", 4'(acc_count - a0), 4'd0);
    key_valid = 1'b0;
    cycles(1);
    key_valid = 1'b1; key_code = 4'h7;
    cycles(3);
    check("rh_repress", digit_right, 4'h7);
    key_valid = 1'b0;
    cycles(2);

    // Fast re-press: 1,0,1 on consecutive edges
    a0 = acc_count;
    key_valid = 1'b1; key_code = 4'h1;
    cycles(1);
    key_valid = 1'b0;
    cycles(1);
    key_valid = 1'b1; key_code = 4'h2;
    cycles(1);
    key_valid = 1'b0;
    cycles(2);
    check("fast_pulses", 4'(acc_count - a0), 4'd2);
    check("fast_left", digit_left, 4'h1);
    check("fast_right", digit_right, 4'h2);

    // Randomized traffic with occasional mid-operation resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        cycles(1);
        reset = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) key_valid = ~key_valid;
      key_code = 4'($urandom_range(0, 15));
      cycles(1);
    end

    key_valid = 1'b0;
    cycles(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
